// File: rtl/gcd_operand_queue.sv
// Operand-pair FIFO and sequencer in front of the gcd core; zero operands bypass the core.
// Optional statistics counters are enabled by defining GCD_QUEUE_STATS_EN.
module gcd_operand_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk_i,
  input  logic                     resetn_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [XLEN-1:0]          req_a_i,
  input  logic [XLEN-1:0]          req_b_i,
  input  logic [TAG_W-1:0]         req_tag_i,
  output logic                     core_start_o,
  output logic [XLEN-1:0]          core_a_o,
  output logic [XLEN-1:0]          core_b_o,
  input  logic                     core_done_i,
  input  logic [XLEN-1:0]          core_gcd_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [XLEN-1:0]          rsp_gcd_o,
  output logic [TAG_W-1:0]         rsp_tag_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
`ifdef GCD_QUEUE_STATS_EN
  ,
  output logic [31:0]              stat_issued_o,
  output logic [31:0]              stat_bypass_o,
  output logic [31:0]              stat_stall_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    mem_a_q   [DEPTH];
  logic [XLEN-1:0]    mem_a_d   [DEPTH];
  logic [XLEN-1:0]    mem_b_q   [DEPTH];
  logic [XLEN-1:0]    mem_b_d   [DEPTH];
  logic [TAG_W-1:0]   mem_tag_q [DEPTH];
  logic [TAG_W-1:0]   mem_tag_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               core_start_q, core_start_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]    core_a_q, core_a_d;
  logic [XLEN-1:0]    core_b_q, core_b_d;
  logic [XLEN-1:0]    rsp_gcd_q, rsp_gcd_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;

  logic               full_c;
  logic               push_c;
  logic               pop_c;
  logic               head_zero_c;
  logic [XLEN-1:0]    head_a_c;
  logic [XLEN-1:0]    head_b_c;
  logic [TAG_W-1:0]   head_tag_c;

  // Ready comes only from the registered count, so a full FIFO never accepts even on a pop cycle.
  assign full_c      = (count_q == CNT_W'(DEPTH));
  assign req_ready_o = ~full_c;
  assign push_c      = req_valid_i & ~full_c;

  assign head_a_c    = mem_a_q[rd_ptr_q];
  assign head_b_c    = mem_b_q[rd_ptr_q];
  assign head_tag_c  = mem_tag_q[rd_ptr_q];
  assign head_zero_c = (head_a_c == '0) || (head_b_c == '0);

  // Next-state, pop decision and operand/result capture.
  always_comb begin
    state_d   = state_q;
    pop_c     = 1'b0;
    core_a_d  = core_a_q;
    core_b_d  = core_b_q;
    rsp_gcd_d = rsp_gcd_q;
    rsp_tag_d = rsp_tag_q;

    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop_c     = 1'b1;
          core_a_d  = head_a_c;
          core_b_d  = head_b_c;
          rsp_tag_d = head_tag_c;
          if (head_zero_c) begin
            // gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0
            rsp_gcd_d = head_a_c | head_b_c;
            state_d   = S_RESP;
          end else begin
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done_i) begin
          rsp_gcd_d = core_gcd_i;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    core_start_d = (state_d == S_ISSUE);
    rsp_valid_d  = (state_d == S_RESP);
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    mem_a_d   = mem_a_q;
    mem_b_d   = mem_b_q;
    mem_tag_d = mem_tag_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (push_c) begin
      mem_a_d[wr_ptr_q]   = req_a_i;
      mem_b_d[wr_ptr_q]   = req_b_i;
      mem_tag_d[wr_ptr_q] = req_tag_i;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      core_start_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      rsp_gcd_q    <= '0;
      rsp_tag_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_a_q[i]   <= '0;
        mem_b_q[i]   <= '0;
        mem_tag_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      core_start_q <= core_start_d;
      rsp_valid_q  <= rsp_valid_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      rsp_gcd_q    <= rsp_gcd_d;
      rsp_tag_q    <= rsp_tag_d;
      mem_a_q      <= mem_a_d;
      mem_b_q      <= mem_b_d;
      mem_tag_q    <= mem_tag_d;
    end
  end

  assign core_start_o = core_start_q;
  assign core_a_o     = core_a_q;
  assign core_b_o     = core_b_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_gcd_o    = rsp_gcd_q;
  assign rsp_tag_o    = rsp_tag_q;
  assign occupancy_o  = count_q;

`ifdef GCD_QUEUE_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_bypass_q, stat_bypass_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // Saturating event counters.
  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_bypass_d = stat_bypass_q;
    stat_stall_d  = stat_stall_q;
    if (core_start_q && (stat_issued_q != '1)) begin
      stat_issued_d = stat_issued_q + 32'(1);
    end
    if (pop_c && head_zero_c && (stat_bypass_q != '1)) begin
      stat_bypass_d = stat_bypass_q + 32'(1);
    end
    if (rsp_valid_q && !rsp_ready_i && (stat_stall_q != '1)) begin
      stat_stall_d = stat_stall_q + 32'(1);
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      stat_issued_q <= '0;
      stat_bypass_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_bypass_q <= stat_bypass_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued_o = stat_issued_q;
  assign stat_bypass_o = stat_bypass_q;
  assign stat_stall_o  = stat_stall_q;
`endif

endmodule

// File: tb/tb_gcd_operand_queue.sv
// Self-checking bench for gcd_operand_queue: directed and random traffic against
// a queue-based reference of expected (gcd, tag) responses and a behavioural gcd core.
module tb_gcd_operand_queue;

  logic        clk_i;
  logic        resetn_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_a_i;
  logic [31:0] req_b_i;
  logic [3:0]  req_tag_i;
  logic        core_start_o;
  logic [31:0] core_a_o;
  logic [31:0] core_b_o;
  logic        core_done_i;
  logic [31:0] core_gcd_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_gcd_o;
  logic [3:0]  rsp_tag_o;
  logic [2:0]  occupancy_o;

  gcd_operand_queue #(.XLEN(32), .DEPTH(4), .TAG_W(4)) dut (
    .clk_i        (clk_i),
    .resetn_i     (resetn_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_tag_i    (req_tag_i),
    .core_start_o (core_start_o),
    .core_a_o     (core_a_o),
    .core_b_o     (core_b_o),
    .core_done_i  (core_done_i),
    .core_gcd_i   (core_gcd_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_gcd_o    (rsp_gcd_o),
    .rsp_tag_o    (rsp_tag_o),
    .occupancy_o  (occupancy_o)
  );

  typedef struct packed {
    logic [31:0] gcd;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   starts;
  bit   acc;
  int   core_lat;
  bit   core_rand;
  int   spur_req;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] t;
    x = a;
    y = b;
    while (y != 32'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Behavioural gcd core: answers each start after a chosen latency; can inject a stray done.
  initial begin
    int          lat;
    int          spur_ack;
    logic [31:0] ca;
    logic [31:0] cb;
    spur_ack    = 0;
    core_done_i = 1'b0;
    core_gcd_i  = 32'd0;
    forever begin
      @(negedge clk_i);
      core_done_i = 1'b0;
      if (spur_req != spur_ack) begin
        spur_ack    = spur_req;
        core_done_i = 1'b1;
        core_gcd_i  = 32'hDEAD_BEEF;
      end else if (core_start_o && resetn_i) begin
        lat = core_rand ? int'($urandom_range(10, 1)) : core_lat;
        ca  = core_a_o;
        cb  = core_b_o;
        repeat (lat) @(negedge clk_i);
        core_done_i = 1'b1;
        core_gcd_i  = ref_gcd(ca, cb);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then score handshakes of this cycle.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic rdy);
    exp_t e;
    @(negedge clk_i);
    req_valid_i = v;
    req_a_i     = a;
    req_b_i     = b;
    req_tag_i   = tag;
    rsp_ready_i = rdy;
    #1;
    acc = 1'b0;
    if (core_start_o) starts++;
    if (rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid_o), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("rsp_gcd", 64'(rsp_gcd_o), 64'(e.gcd));
        check("rsp_tag", 64'(rsp_tag_o), 64'(e.tag));
      end
    end
    if (req_valid_i && req_ready_o) begin
      exp_q.push_back({ref_gcd(a, b), tag});
      acc = 1'b1;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                      input bit rand_rdy);
    int n;
    n = 0;
    do begin
      step(1'b1, a, b, tag, rand_rdy ? 1'($urandom_range(1, 0)) : 1'b0);
      n++;
    end while (!acc && n < 300);
    if (!acc) check("send_timeout", 64'(acc), 64'(1));
  endtask

  task automatic drain(input bit rand_rdy, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1'b0, 32'd0, 32'd0, 4'd0, rand_rdy ? 1'($urandom_range(1, 0)) : 1'b1);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'(0));
    step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
  endtask

  initial begin
    int s0;
    int n;
    logic [31:0] g;
    logic [31:0] a;
    logic [31:0] b;
    checks      = 0;
    errors      = 0;
    starts      = 0;
    acc         = 1'b0;
    core_lat    = 3;
    core_rand   = 1'b0;
    spur_req    = 0;
    resetn_i    = 1'b0;
    req_valid_i = 1'b0;
    req_a_i     = 32'd0;
    req_b_i     = 32'd0;
    req_tag_i   = 4'd0;
    rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    resetn_i = 1'b1;
    step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    check("rst_ready", 64'(req_ready_o), 64'(1));
    check("rst_occ", 64'(occupancy_o), 64'(0));
    check("rst_start", 64'(core_start_o), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    check("rst_core_a", 64'(core_a_o), 64'(0));
    check("rst_rsp_gcd", 64'(rsp_gcd_o), 64'(0));
    check("rst_rsp_tag", 64'(rsp_tag_o), 64'(0));

    // Single request through the core, with latency checks.
    step(1'b1, 32'd48, 32'd18, 4'd5, 1'b0);
    check("single_acc", 64'(acc), 64'(1));
    step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    check("single_occ", 64'(occupancy_o), 64'(1));
    check("single_nostart", 64'(core_start_o), 64'(0));
    step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    check("single_start", 64'(core_start_o), 64'(1));
    check("single_core_a", 64'(core_a_o), 64'(48));
    check("single_core_b", 64'(core_b_o), 64'(18));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
      check("single_start_pulse", 64'(core_start_o), 64'(0));
      check("single_wait_valid", 64'(rsp_valid_o), 64'(0));
    end
    step(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    check("single_rsp_valid", 64'(rsp_valid_o), 64'(1));
    check("single_rsp_gcd", 64'(rsp_gcd_o), 64'(6));
    check("single_rsp_tag", 64'(rsp_tag_o), 64'(5));
    drain(1'b0, 20);

    // Zero bypass: no core starts, response two cycles after accept.
    s0 = starts;
    step(1'b1, 32'd0, 32'd35, 4'd1, 1'b0);
    step(1'b1, 32'd35, 32'd0, 4'd2, 1'b0);
    step(1'b1, 32'd0, 32'd0, 4'd3, 1'b0);
    check("bypass_valid", 64'(rsp_valid_o), 64'(1));
    check("bypass_gcd", 64'(rsp_gcd_o), 64'(35));
    check("bypass_tag", 64'(rsp_tag_o), 64'(1));
    drain(1'b0, 30);
    check("bypass_no_start", 64'(starts - s0), 64'(0));

    // Full FIFO with the response channel stalled.
    core_lat = 2;
    send(32'd0, 32'd9, 4'd0, 1'b0);
    send(32'd24, 32'd36, 4'd1, 1'b0);
    send(32'd0, 32'd0, 4'd2, 1'b0);
    send(32'd14, 32'd21, 4'd3, 1'b0);
    send(32'd5, 32'd0, 4'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'd7, 32'd7, 4'd5, 1'b0);
      check("full_ready", 64'(req_ready_o), 64'(0));
      check("full_occ", 64'(occupancy_o), 64'(4));
      check("full_no_acc", 64'(acc), 64'(0));
    end
    n = 0;
    do begin
      step(1'b1, 32'd7, 32'd7, 4'd5, 1'b1);
      n++;
    end while (!acc && n < 20);
    check("full_late_acc", 64'(acc), 64'(1));
    drain(1'b0, 100);

    // Backpressure holds the response; a stray done in RESP is ignored.
    send(32'd100, 32'd75, 4'd7, 1'b0);
    n = 0;
    while (!rsp_valid_o && n < 50) begin
      step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
      n++;
    end
    check("bp_valid", 64'(rsp_valid_o), 64'(1));
    for (int i = 0; i < 5; i++) begin
      if (i == 1) spur_req++;
      step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
      check("bp_valid_hold", 64'(rsp_valid_o), 64'(1));
      check("bp_gcd_hold", 64'(rsp_gcd_o), 64'(25));
      check("bp_tag_hold", 64'(rsp_tag_o), 64'(7));
    end
    drain(1'b0, 10);

    // Ordering stress: random operands (with zeros), core latency and response ready.
    core_rand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      g = 32'($urandom_range(40, 1));
      a = ($urandom_range(4, 0) == 0) ? 32'd0 : g * 32'($urandom_range(500, 1));
      b = ($urandom_range(4, 0) == 0) ? 32'd0 : g * 32'($urandom_range(500, 1));
      send(a, b, 4'(i), 1'b1);
    end
    drain(1'b1, 2000);
    core_rand = 1'b0;

    // Asynchronous reset mid-WAIT with three entries still queued.
    core_lat = 40;
    send(32'd12, 32'd8, 4'd1, 1'b0);
    send(32'd9, 32'd6, 4'd2, 1'b0);
    send(32'd10, 32'd4, 4'd3, 1'b0);
    send(32'd21, 32'd14, 4'd4, 1'b0);
    step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    check("pre_rst_occ", 64'(occupancy_o), 64'(3));
    resetn_i = 1'b0;
    #1;
    check("arst_occ", 64'(occupancy_o), 64'(0));
    check("arst_ready", 64'(req_ready_o), 64'(1));
    check("arst_start", 64'(core_start_o), 64'(0));
    check("arst_valid", 64'(rsp_valid_o), 64'(0));
    check("arst_core_a", 64'(core_a_o), 64'(0));
    check("arst_core_b", 64'(core_b_o), 64'(0));
    check("arst_gcd", 64'(rsp_gcd_o), 64'(0));
    check("arst_tag", 64'(rsp_tag_o), 64'(0));
    exp_q.delete();
    repeat (3) step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    resetn_i = 1'b1;
    step(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    check("post_rst_occ", 64'(occupancy_o), 64'(0));
    check("post_rst_ready", 64'(req_ready_o), 64'(1));
    repeat (50) step(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    check("post_rst_idle_valid", 64'(rsp_valid_o), 64'(0));
    send(32'd0, 32'd77, 4'd9, 1'b0);
    drain(1'b0, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
